spi_cfg_seq: RTL and testbench
==============================

# spi_cfg_seq

Parametrised, table-driven SPI configuration sequencer; successor to the fixed write-then-verify-then-PLL-check loader. It walks an external command LUT in which each entry is WRITE, WRITE+VERIFY, POLL or END. It drives one SPI register controller through a pulse request / pulse acknowledge handshake, and reports done, error code and failing index. It sits between the device init LUT ROM and the shared SPI controller on the DAC/clock-chip configuration path.

## Interface
Parameters:
- ADDR_W, 16, SPI register address width
- DATA_W, 8, SPI register data width
- IDX_W, 10, LUT index width
- RETRY_MAX, 2, re-writes allowed after a failed verify
- POLL_MAX, 16, maximum poll reads per POLL entry
- POLL_WAIT, 50000, idle clk cycles between poll reads (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin sequence at index 0; level-sampled in IDLE/DONE only
- abort  in  1  terminate sequence
- lut_index  out  IDX_W  current LUT entry
- lut_op  in  2  00 WRITE, 01 WRITE+VERIFY, 10 POLL, 11 END
- lut_addr  in  ADDR_W  register address
- lut_data  in  DATA_W  write value / expected value
- lut_mask  in  DATA_W  compare mask for VERIFY and POLL
- spi_wr_req  out  1  one-cycle write request
- spi_rd_req  out  1  one-cycle read request
- spi_addr  out  ADDR_W  address to controller
- spi_wdata  out  DATA_W  write data to controller
- spi_wr_done  in  1  one-cycle write completion
- spi_rd_valid  in  1  one-cycle read completion, spi_rdata valid
- spi_rdata  in  DATA_W  read data
- spi_busy  in  1  controller busy
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse at sequence termination (END or error)
- error  out  1  sticky failure flag, cleared on accepted start
- err_code  out  2  0 none, 1 verify fail, 2 poll timeout, 3 table overrun
- err_index  out  IDX_W  lut_index of the failing entry
- last_rdata  out  DATA_W  most recent spi_rdata captured

## Operation
- States: IDLE, WAIT_CTRL, FETCH, WR, WR_ACK, VF_RD, VF_ACK, PL_RD, PL_ACK, PL_WAIT, DONE.
- The LUT is combinational from lut_index. Entry fields are sampled only in FETCH; spi_addr and spi_wdata are registered from them in FETCH and held until the next FETCH.
- IDLE/DONE + start: clear error, err_code, err_index; lut_index←0; go to WAIT_CTRL.
- WAIT_CTRL: stay while spi_busy=1, then go to FETCH. A busy controller at start delays the sequence; the start is not dropped.
- FETCH, by op:
  - END: pulse done, go to DONE.
  - WRITE/WRITE+VERIFY: go to WR, retry counter←0.
  - POLL: go to PL_RD, poll counter←0.
- WR: assert spi_wr_req for one cycle, go to WR_ACK. WR_ACK waits for spi_wr_done.
  - WRITE: advance.
  - WRITE+VERIFY: go to VF_RD.
- VF_RD: assert spi_rd_req for one cycle, go to VF_ACK. On spi_rd_valid, capture last_rdata and compare (spi_rdata & mask) == (data & mask):
  - Match: advance.
  - Mismatch, retries < RETRY_MAX: retries+1, go to WR.
  - Otherwise: fail with code 1.
- PL_RD: one-cycle spi_rd_req, go to PL_ACK. On spi_rd_valid, apply the same compare:
  - Match: advance.
  - Mismatch, polls+1 < POLL_MAX: go to PL_WAIT, wait POLL_WAIT cycles, then PL_RD.
  - Otherwise: fail with code 2.
- Advance: if lut_index == 2^IDX_W−1, fail with code 3. Otherwise lut_index+1, go to FETCH.
- Fail: error←1, err_code, err_index←lut_index, pulse done, go to DONE.
- abort (any busy state):
  - If no request is outstanding (WAIT_CTRL, FETCH, WR, VF_RD, PL_RD, PL_WAIT), go to IDLE next cycle.
  - In *_ACK states, wait for the ack, then go to IDLE.
  - An abort never pulses done and never sets error. abort has priority over start in the same cycle.
- DONE holds lut_index, error, err_code and err_index until the next start.

## Timing
- Reset values: lut_index 0, spi_wr_req 0, spi_rd_req 0, spi_addr 0, spi_wdata 0, busy 0, done 0, error 0, err_code 0, err_index 0, last_rdata 0. State is IDLE.
- A reset mid-transaction returns to IDLE immediately. Acks arriving afterwards are ignored.
- start → first spi_wr_req = 3 cycles with spi_busy=0 (WAIT_CTRL, FETCH, WR).
- Ack → next request = 3 cycles for a non-final WRITE (ACK, FETCH, WR). Ack → VF_RD request = 2 cycles.
- Poll spacing: spi_rd_valid → next spi_rd_req = POLL_WAIT+2 cycles.
- Ack pulses arriving outside an *_ACK state are ignored.
- done is asserted exactly one cycle, in the cycle the state enters DONE. error and err_code are valid in that same cycle.

## Test plan
- Three WRITE entries then END, controller acks after 10 cycles → three wr_req with addr/data matching the LUT, lut_index 0,1,2,3, one done pulse, error=0.
- WRITE+VERIFY data 0xA5 mask 0xF0; readbacks 0x00, 0x00, 0xA0 with RETRY_MAX=2 → three writes, pass, no error. With readback always 0x00 → error=1, err_code=1, err_index=entry index after 3 writes.
- POLL expecting bit0=1, POLL_WAIT=4, POLL_MAX=3; readbacks 0x00, 0x00, 0x01 → reads spaced 6 cycles apart, advance. With readback always 0x00 → err_code=2 after exactly 3 reads.
- IDX_W=2 with no END in the table → err_code=3, err_index=3.
- abort during WR_ACK → no further requests after the ack, IDLE, done never pulses. start+abort in the same cycle → stays IDLE.
- spi_busy=1 for 20 cycles at start → first wr_req on cycle 22. A start issued from DONE reruns the sequence from index 0 with error cleared.

Source files
------------

// File: rtl/spi_cfg_seq.sv
// Table-driven SPI configuration sequencer: walks a WRITE / WRITE+VERIFY / POLL / END command LUT.
// Drives one SPI register controller with one-cycle requests and waits for its one-cycle acks.
module spi_cfg_seq #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 10,
  parameter int RETRY_MAX = 2,
  parameter int POLL_MAX  = 16,
  parameter int POLL_WAIT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [IDX_W-1:0]  lut_index,
  input  logic [1:0]        lut_op,
  input  logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  input  logic [DATA_W-1:0] lut_mask,
  output logic              spi_wr_req,
  output logic              spi_rd_req,
  output logic [ADDR_W-1:0] spi_addr,
  output logic [DATA_W-1:0] spi_wdata,
  input  logic              spi_wr_done,
  input  logic              spi_rd_valid,
  input  logic [DATA_W-1:0] spi_rdata,
  input  logic              spi_busy,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [IDX_W-1:0]  err_index,
  output logic [DATA_W-1:0] last_rdata
);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_WV   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_END  = 2'b11;

  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int PW = (POLL_MAX > 0) ? $clog2(POLL_MAX + 1) : 1;
  localparam int WW = (POLL_WAIT > 1) ? $clog2(POLL_WAIT + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [PW-1:0] POLL_LIM  = PW'(POLL_MAX);
  localparam logic [WW-1:0] WAIT_INIT = WW'(POLL_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_CTRL, S_FETCH, S_WR, S_WR_ACK, S_VF_RD, S_VF_ACK,
    S_PL_RD, S_PL_ACK, S_PL_WAIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    lut_index_q, lut_index_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]   spi_addr_q, spi_addr_d;
  logic [DATA_W-1:0]   spi_wdata_q, spi_wdata_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [PW-1:0]       poll_q, poll_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic                abort_pend_q, abort_pend_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [IDX_W-1:0]    err_index_q, err_index_d;
  logic [DATA_W-1:0]   last_rdata_q, last_rdata_d;

  logic       match, abort_now, do_adv, do_fail;
  logic [1:0] fail_code;

  assign match     = (spi_rdata & mask_q) == (spi_wdata_q & mask_q);
  assign abort_now = abort | abort_pend_q;

  always_comb begin
    state_d      = state_q;
    lut_index_d  = lut_index_q;
    op_d         = op_q;
    mask_d       = mask_q;
    spi_addr_d   = spi_addr_q;
    spi_wdata_d  = spi_wdata_q;
    retry_d      = retry_q;
    poll_d       = poll_q;
    wait_d       = wait_q;
    abort_pend_d = abort_pend_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    err_index_d  = err_index_q;
    last_rdata_d = last_rdata_q;
    do_adv       = 1'b0;
    do_fail      = 1'b0;
    fail_code    = 2'd0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          error_d     = 1'b0;
          err_code_d  = 2'd0;
          err_index_d = '0;
          lut_index_d = '0;
          state_d     = S_WAIT_CTRL;
        end
      end
      S_WAIT_CTRL: begin
        if (abort)          state_d = S_IDLE;
        else if (!spi_busy) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          op_d        = lut_op;
          mask_d      = lut_mask;
          spi_addr_d  = lut_addr;
          spi_wdata_d = lut_data;
          case (lut_op)
            OP_END:  state_d = S_DONE;
            OP_POLL: begin state_d = S_PL_RD; poll_d = '0; end
            default: begin state_d = S_WR; retry_d = '0; end
          endcase
        end
      end
      S_WR:    state_d = abort ? S_IDLE : S_WR_ACK;
      S_VF_RD: state_d = abort ? S_IDLE : S_VF_ACK;
      S_PL_RD: state_d = abort ? S_IDLE : S_PL_ACK;
      // An abort seen while a request is in flight is held until the ack retires it.
      S_WR_ACK: begin
        if (abort) abort_pend_d = 1'b1;
        if (spi_wr_done) begin
          if (abort_now)         state_d = S_IDLE;
          else if (op_q == OP_WV) state_d = S_VF_RD;
          else                   do_adv  = 1'b1;
        end
      end
      S_VF_ACK: begin
        if (abort) abort_pend_d = 1'b1;
        if (spi_rd_valid) begin
          last_rdata_d = spi_rdata;
          if (abort_now) begin
            state_d = S_IDLE;
          end else if (match) begin
            do_adv = 1'b1;
          end else if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RW'(1);
            state_d = S_WR;
          end else begin
            do_fail   = 1'b1;
            fail_code = 2'd1;
          end
        end
      end
      S_PL_ACK: begin
        if (abort) abort_pend_d = 1'b1;
        if (spi_rd_valid) begin
          last_rdata_d = spi_rdata;
          if (abort_now) begin
            state_d = S_IDLE;
          end else if (match) begin
            do_adv = 1'b1;
          end else if (poll_q + PW'(1) < POLL_LIM) begin
            poll_d  = poll_q + PW'(1);
            wait_d  = WAIT_INIT;
            state_d = S_PL_WAIT;
          end else begin
            do_fail   = 1'b1;
            fail_code = 2'd2;
          end
        end
      end
      S_PL_WAIT: begin
        if (abort)             state_d = S_IDLE;
        else if (wait_q == '0) state_d = S_PL_RD;
        else                   wait_d  = wait_q - WW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (do_adv) begin
      if (lut_index_q == '1) begin
        do_fail   = 1'b1;
        fail_code = 2'd3;
      end else begin
        lut_index_d = lut_index_q + IDX_W'(1);
        state_d     = S_FETCH;
      end
    end
    if (do_fail) begin
      error_d     = 1'b1;
      err_code_d  = fail_code;
      err_index_d = lut_index_q;
      state_d     = S_DONE;
    end
    if (state_d == S_IDLE) abort_pend_d = 1'b0;
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lut_index_q  <= '0;
      op_q         <= OP_WR;
      mask_q       <= '0;
      spi_addr_q   <= '0;
      spi_wdata_q  <= '0;
      retry_q      <= '0;
      poll_q       <= '0;
      wait_q       <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'd0;
      err_index_q  <= '0;
      last_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      lut_index_q  <= lut_index_d;
      op_q         <= op_d;
      mask_q       <= mask_d;
      spi_addr_q   <= spi_addr_d;
      spi_wdata_q  <= spi_wdata_d;
      retry_q      <= retry_d;
      poll_q       <= poll_d;
      wait_q       <= wait_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      err_index_q  <= err_index_d;
      last_rdata_q <= last_rdata_d;
    end
  end

  // Requests are suppressed in an abort cycle so nothing is left outstanding.
  assign spi_wr_req = (state_q == S_WR) && !abort;
  assign spi_rd_req = ((state_q == S_VF_RD) || (state_q == S_PL_RD)) && !abort;
  assign spi_addr   = spi_addr_q;
  assign spi_wdata  = spi_wdata_q;
  assign lut_index  = lut_index_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign err_index  = err_index_q;
  assign last_rdata = last_rdata_q;

endmodule

// File: tb/tb_spi_cfg_seq.sv
// Directed bench for spi_cfg_seq: LUT array, SPI controller responder and cycle-stamped request log.
module tb_spi_cfg_seq;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [IW-1:0] lut_index;
  logic [1:0]    lut_op;
  logic [AW-1:0] lut_addr;
  logic [DW-1:0] lut_data, lut_mask;
  logic          spi_wr_req, spi_rd_req;
  logic [AW-1:0] spi_addr;
  logic [DW-1:0] spi_wdata;
  logic          spi_wr_done = 1'b0, spi_rd_valid = 1'b0;
  logic [DW-1:0] spi_rdata = '0;
  logic          spi_busy;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [IW-1:0] err_index;
  logic [DW-1:0] last_rdata;

  logic [1:0]    t_op [4];
  logic [AW-1:0] t_addr [4];
  logic [DW-1:0] t_data [4];
  logic [DW-1:0] t_mask [4];
  assign lut_op   = t_op[lut_index];
  assign lut_addr = t_addr[lut_index];
  assign lut_data = t_data[lut_index];
  assign lut_mask = t_mask[lut_index];

  spi_cfg_seq #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW), .RETRY_MAX(2), .POLL_MAX(3), .POLL_WAIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lut_index(lut_index),
    .lut_op(lut_op), .lut_addr(lut_addr), .lut_data(lut_data), .lut_mask(lut_mask),
    .spi_wr_req(spi_wr_req), .spi_rd_req(spi_rd_req), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_wr_done(spi_wr_done), .spi_rd_valid(spi_rd_valid), .spi_rdata(spi_rdata), .spi_busy(spi_busy),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
    .last_rdata(last_rdata)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller model and request log, evaluated mid-cycle.
  int            ack_dly = 1;
  int            wr_cnt = 0, rd_cnt = 0;
  int            wr_n = 0, rd_n = 0, done_cnt = 0;
  int            wr_cyc [16];
  int            rd_cyc [16];
  logic [AW-1:0] wr_addr [16];
  logic [DW-1:0] wr_data [16];
  logic [IW-1:0] wr_idx [16];
  logic [DW-1:0] rb_q [$];
  logic [DW-1:0] rb_def = '0;
  logic          d_err;
  logic [1:0]    d_code;
  logic [IW-1:0] d_idx, d_lut;

  always @(negedge clk) begin
    spi_wr_done  = 1'b0;
    spi_rd_valid = 1'b0;
    if (wr_cnt > 0) begin
      wr_cnt--;
      if (wr_cnt == 0) spi_wr_done = 1'b1;
    end
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        spi_rd_valid = 1'b1;
        if (rb_q.size() > 0) spi_rdata = rb_q.pop_front();
        else                 spi_rdata = rb_def;
      end
    end
    if (spi_wr_req) begin
      if (wr_n < 16) begin
        wr_cyc[wr_n] = cyc; wr_addr[wr_n] = spi_addr; wr_data[wr_n] = spi_wdata; wr_idx[wr_n] = lut_index;
      end
      wr_n++;
      wr_cnt = ack_dly;
    end
    if (spi_rd_req) begin
      if (rd_n < 16) rd_cyc[rd_n] = cyc;
      rd_n++;
      rd_cnt = ack_dly;
    end
    if (done) begin
      done_cnt++;
      d_err = error; d_code = err_code; d_idx = err_index; d_lut = lut_index;
    end
  end

  int start_cyc = 0;

  task automatic set_ent(input int i, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
    t_op[i] = op; t_addr[i] = a; t_data[i] = d; t_mask[i] = m;
  endtask

  task automatic load_t1();
    set_ent(0, 2'b00, 16'h1234, 8'h11, 8'hFF);
    set_ent(1, 2'b00, 16'h2345, 8'h22, 8'hFF);
    set_ent(2, 2'b00, 16'h3456, 8'h33, 8'hFF);
    set_ent(3, 2'b11, 16'h0000, 8'h00, 8'h00);
  endtask

  task automatic clr(input int dly);
    wr_n = 0; rd_n = 0; rb_q.delete(); rb_def = '0; ack_dly = dly;
  endtask

  task automatic go();
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk); n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk(tag, done_cnt - d0, 1);
  endtask

  initial begin
    int d0, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; spi_busy = 1'b0;
    load_t1();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_outs", {busy, done, error, spi_wr_req, spi_rd_req}, 0);
    chk("rst_idx", {lut_index, err_code, err_index}, 0);
    chk("rst_data", {spi_addr, spi_wdata, last_rdata}, 0);

    // Three writes then END, 10-cycle acks.
    clr(10); d0 = done_cnt;
    go();
    wait_done("t1_done", d0);
    chk("t1_nwr", wr_n, 3);
    chk("t1_lat", wr_cyc[0] - start_cyc, 3);
    chk("t1_gap", wr_cyc[1] - wr_cyc[0], 12);
    chk("t1_w0", {wr_addr[0], wr_data[0], 6'd0, wr_idx[0]}, {16'h1234, 8'h11, 8'd0});
    chk("t1_w1", {wr_addr[1], wr_data[1], 6'd0, wr_idx[1]}, {16'h2345, 8'h22, 8'd1});
    chk("t1_w2", {wr_addr[2], wr_data[2], 6'd0, wr_idx[2]}, {16'h3456, 8'h33, 8'd2});
    chk("t1_end", {d_err, d_code, d_lut}, {1'b0, 2'd0, 2'd3});
    chk("t1_idle", busy, 0);

    // WRITE+VERIFY passing on the third readback.
    set_ent(0, 2'b01, 16'h0100, 8'hA5, 8'hF0);
    set_ent(1, 2'b11, 16'h0000, 8'h00, 8'h00);
    clr(2); rb_q.push_back(8'h00); rb_q.push_back(8'h00); rb_q.push_back(8'hA0);
    d0 = done_cnt;
    go();
    wait_done("vf_done", d0);
    chk("vf_nwr", wr_n, 3);
    chk("vf_nrd", rd_n, 3);
    chk("vf_rdlat", rd_cyc[0] - wr_cyc[0], 3);
    chk("vf_end", {d_err, d_code, d_lut}, {1'b0, 2'd0, 2'd1});
    chk("vf_rdata", last_rdata, 8'hA0);

    // WRITE+VERIFY never matching.
    clr(2); d0 = done_cnt;
    go();
    wait_done("vfx_done", d0);
    chk("vfx_nwr", wr_n, 3);
    chk("vfx_err", {d_err, d_code, d_idx}, {1'b1, 2'd1, 2'd0});

    // POLL passing on the third read.
    set_ent(0, 2'b10, 16'h0200, 8'h01, 8'h01);
    clr(1); rb_q.push_back(8'h00); rb_q.push_back(8'h00); rb_q.push_back(8'h01);
    d0 = done_cnt;
    go();
    chk("pl_errclr", error, 0);
    wait_done("pl_done", d0);
    chk("pl_nrd", rd_n, 3);
    chk("pl_gap1", rd_cyc[1] - rd_cyc[0], 6);
    chk("pl_gap2", rd_cyc[2] - rd_cyc[1], 6);
    chk("pl_end", {d_err, d_code, d_lut, 4'(wr_n)}, {1'b0, 2'd0, 2'd1, 4'd0});

    // POLL timeout.
    clr(1); d0 = done_cnt;
    go();
    wait_done("plx_done", d0);
    repeat (20) @(posedge clk);
    chk("plx_nrd", rd_n, 3);
    chk("plx_err", {d_err, d_code, d_idx}, {1'b1, 2'd2, 2'd0});

    // Table without END overruns the index range.
    for (int i = 0; i < 4; i++) set_ent(i, 2'b00, AW'(16'h0400 + i), DW'(i), 8'hFF);
    clr(1); d0 = done_cnt;
    go();
    wait_done("ovr_done", d0);
    chk("ovr_nwr", wr_n, 4);
    chk("ovr_err", {d_err, d_code, d_idx}, {1'b1, 2'd3, 2'd3});

    // Abort while waiting for a write ack.
    load_t1(); clr(10); d0 = done_cnt;
    go();
    n = 0;
    while (wr_n == 0 && n < 100) begin @(posedge clk); n++; end
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("ab_hold", busy, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("ab_idle", {busy, error}, 0);
    chk("ab_nwr", wr_n, 1);
    chk("ab_nodone", done_cnt - d0, 0);

    // start and abort together are ignored.
    clr(1); d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("sa_nwr", wr_n + (done_cnt - d0), 0);

    // Controller busy for 20 cycles at start.
    clr(10); d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; spi_busy = 1'b1; start_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 spi_busy = 1'b0;
    wait_done("bz_done", d0);
    chk("bz_lat", wr_cyc[0] - start_cyc, 22);
    chk("bz_end", {d_err, d_code, d_lut, 4'(wr_n)}, {1'b0, 2'd0, 2'd3, 4'd3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
